// File: rtl/ex_mem_stage_buf.sv
// EX->MEM stage for the SIMD AES datapath: 2-entry skid buffer (main + skid)
// with registered in_ready, synchronous flush and bubble-masked control.

module ex_mem_lane_buf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_in_main_i,
  input  logic              ld_skid_main_i,
  input  logic              ld_skid_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              mask_i,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] wd_o,
  output logic              mask_o
);
  logic [DATA_W-1:0] main_alu_q, main_wd_q, skid_alu_q, skid_wd_q;
  logic              main_mask_q, skid_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_alu_q  <= '0;
      main_wd_q   <= '0;
      main_mask_q <= 1'b0;
      skid_alu_q  <= '0;
      skid_wd_q   <= '0;
      skid_mask_q <= 1'b0;
    end else begin
      if (ld_in_main_i) begin
        main_alu_q  <= alu_i;
        main_wd_q   <= wd_i;
        main_mask_q <= mask_i;
      end else if (ld_skid_main_i) begin
        main_alu_q  <= skid_alu_q;
        main_wd_q   <= skid_wd_q;
        main_mask_q <= skid_mask_q;
      end
      if (ld_skid_i) begin
        skid_alu_q  <= alu_i;
        skid_wd_q   <= wd_i;
        skid_mask_q <= mask_i;
      end
    end
  end

  assign alu_o  = main_alu_q;
  assign wd_o   = main_wd_q;
  assign mask_o = main_mask_q;
endmodule

module ex_mem_stage_buf #(
  parameter int DATA_W = 64,
  parameter int LANES  = 4,
  parameter int RD_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_alu_result,
  input  logic [LANES*DATA_W-1:0] in_write_data,
  input  logic [LANES-1:0]        in_lane_mask,
  input  logic [RD_W-1:0]         in_rd,
  input  logic                    in_reg_write,
  input  logic                    in_mem_to_reg,
  input  logic                    in_mem_write,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_alu_result,
  output logic [LANES*DATA_W-1:0] out_write_data,
  output logic [LANES-1:0]        out_lane_mask,
  output logic [RD_W-1:0]         out_rd,
  output logic                    out_reg_write,
  output logic                    out_mem_to_reg,
  output logic                    out_mem_write,
  output logic [1:0]              occupancy
);
  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
  } ctrl_t;

  state_t state_q, state_d;
  logic   in_ready_q, out_valid_q;
  ctrl_t  main_ctrl_q, skid_ctrl_q, in_ctrl;
  logic   accept, drain, ld_in_main, ld_skid_main, ld_skid;

  logic [LANES-1:0][DATA_W-1:0] in_alu_l, in_wd_l, out_alu_l, out_wd_l;
  logic [LANES-1:0]             out_mask_raw;

  assign accept  = in_valid & in_ready_q & ~flush;
  assign drain   = out_valid_q & out_ready;
  assign in_ctrl = '{rd: in_rd, reg_write: in_reg_write,
                     mem_to_reg: in_mem_to_reg, mem_write: in_mem_write};

  always_comb begin
    state_d      = state_q;
    ld_in_main   = 1'b0;
    ld_skid_main = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d    = ONE;
          ld_in_main = 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            ld_in_main = 1'b1;
          end else if (accept) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: if (drain) begin
          state_d      = ONE;
          ld_skid_main = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (ld_in_main)        main_ctrl_q <= in_ctrl;
      else if (ld_skid_main) main_ctrl_q <= skid_ctrl_q;
      if (ld_skid)           skid_ctrl_q <= in_ctrl;
    end
  end

  assign in_alu_l = in_alu_result;
  assign in_wd_l  = in_write_data;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ex_mem_lane_buf #(.DATA_W(DATA_W)) u_lane (
      .clk            (clk),
      .rst_n          (rst_n),
      .ld_in_main_i   (ld_in_main),
      .ld_skid_main_i (ld_skid_main),
      .ld_skid_i      (ld_skid),
      .alu_i          (in_alu_l[l]),
      .wd_i           (in_wd_l[l]),
      .mask_i         (in_lane_mask[l]),
      .alu_o          (out_alu_l[l]),
      .wd_o           (out_wd_l[l]),
      .mask_o         (out_mask_raw[l])
    );
  end

  // Side-effecting controls read 0 during bubbles; data fields just hold.
  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_alu_result = out_alu_l;
  assign out_write_data = out_wd_l;
  assign out_lane_mask  = out_mask_raw & {LANES{out_valid_q}};
  assign out_rd         = main_ctrl_q.rd;
  assign out_reg_write  = main_ctrl_q.reg_write & out_valid_q;
  assign out_mem_to_reg = main_ctrl_q.mem_to_reg;
  assign out_mem_write  = main_ctrl_q.mem_write & out_valid_q;
  assign occupancy      = state_q;
endmodule
